vga_text_timing: RTL and testbench

Parametrised raster and text-cell sequencer for the text video adapter. It generates HS/VS/DE for any VESA-style mode and walks a COLS×ROWS character grid, issuing one VRAM fetch per cell with the glyph row index. It also produces a frame-counted cursor blink and a cursor-hit flag. It sits between the pixel clock and the VRAM/char-ROM/shift-register datapath, and its delayed sync outputs line up with that datapath's latency.

---
 rtl/vga_text_timing.sv | 218 +++++++++++++++++++++
 tb/tb_vga_text_timing.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_timing.sv
// Raster and text-cell sequencer: generates delayed HS/VS/DE, walks the character grid issuing one
// VRAM fetch per cell with its glyph row, and produces the cursor blink phase and cursor-hit flag.
module vga_text_timing #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_FP         = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BP         = 48,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FP         = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 33,
    parameter bit          HS_POL       = 1'b0,
    parameter bit          VS_POL       = 1'b0,
    parameter int unsigned CHAR_W       = 8,
    parameter int unsigned CHAR_H       = 16,
    parameter int unsigned COLS         = 80,
    parameter int unsigned ROWS         = 30,
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned PIPE_DLY     = 2,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic [ADDR_W-1:0]         i_cur_adr,
    input  logic                      i_cur_en,
    output logic                      o_hs,
    output logic                      o_vs,
    output logic                      o_de,
    output logic                      o_vram_re,
    output logic [ADDR_W-1:0]         o_vram_addr,
    output logic [$clog2(CHAR_H)-1:0] o_glyph_row,
    output logic                      o_cursor_hit,
    output logic                      o_blink,
    output logic                      o_frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One spare bit so the sync end bound still fits when the back porch is zero.
    localparam int unsigned HW  = $clog2(H_TOTAL + 1);
    localparam int unsigned VW  = $clog2(V_TOTAL + 1);
    localparam int unsigned PXW = $clog2(CHAR_W);
    localparam int unsigned GRW = $clog2(CHAR_H);
    localparam int unsigned FCW = $clog2(BLINK_FRAMES + 1);

    localparam logic [HW-1:0]     HLast    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]     HsStart  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]     HsEnd    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0]     HText    = HW'(COLS * CHAR_W);
    localparam logic [VW-1:0]     VLast    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]     VsStart  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]     VsEnd    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0]     VText    = VW'(ROWS * CHAR_H);
    localparam logic [PXW-1:0]    PxLast   = PXW'(CHAR_W - 1);
    localparam logic [GRW-1:0]    GrLast   = GRW'(CHAR_H - 1);
    localparam logic [GRW-1:0]    GrCurMin = GRW'(CHAR_H - 2);
    localparam logic [ADDR_W-1:0] ColsA    = ADDR_W'(COLS);
    localparam logic [FCW-1:0]    FcLast   = FCW'(BLINK_FRAMES - 1);

    // Raster and cell state
    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic [PXW-1:0]    px_q, px_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [GRW-1:0]    gr_q, gr_d;
    logic [FCW-1:0]    fc_q, fc_d;
    logic              blink_q, blink_d;

    // Fetch-stage registers
    logic              re_q, fs_q, hit_q;
    logic [ADDR_W-1:0] addr_q;
    logic [GRW-1:0]    row_q;

    // Sync/DE delay line; stage 0 lines up with the fetch outputs
    logic [PIPE_DLY:0] hs_pipe_q, vs_pipe_q, de_pipe_q;

    logic              h_wrap, v_wrap, in_text, fetch, frame_evt, hs_raw, vs_raw, hit_d;
    logic [ADDR_W-1:0] cell_addr;

    // Decode the current raster position
    always_comb begin
        h_wrap    = (h_q == HLast);
        v_wrap    = (v_q == VLast);
        in_text   = (h_q < HText) && (v_q < VText);
        fetch     = in_text && (px_q == '0);
        frame_evt = (h_q == '0) && (v_q == '0);
        cell_addr = row_base_q + col_q;
        hs_raw    = ((h_q >= HsStart) && (h_q < HsEnd)) ? HS_POL : ~HS_POL;
        vs_raw    = ((v_q >= VsStart) && (v_q < VsEnd)) ? VS_POL : ~VS_POL;
    end

    // Next-state for counters, cell tracking and blink phase
    always_comb begin
        h_d        = h_q;
        v_d        = v_q;
        px_d       = px_q;
        col_d      = col_q;
        gr_d       = gr_q;
        row_base_d = row_base_q;
        fc_d       = fc_q;
        blink_d    = blink_q;
        if (h_wrap) begin
            h_d   = '0;
            px_d  = '0;
            col_d = '0;
            if (v_wrap) begin
                v_d        = '0;
                gr_d       = '0;
                row_base_d = '0;
            end else begin
                v_d = v_q + 1'b1;
                if (v_q < VText) begin
                    gr_d = gr_q + 1'b1;
                    // Running row base replaces a row*COLS multiply.
                    if (gr_q == GrLast) begin
                        row_base_d = row_base_q + ColsA;
                    end
                end
            end
        end else begin
            h_d = h_q + 1'b1;
            if (h_q < HText) begin
                px_d = px_q + 1'b1;
                if (px_q == PxLast) begin
                    col_d = col_q + 1'b1;
                end
            end
        end
        if (frame_evt) begin
            if (fc_q == FcLast) begin
                fc_d    = '0;
                blink_d = ~blink_q;
            end else begin
                fc_d = fc_q + 1'b1;
            end
        end
    end

    // Uses the new blink phase so the flag agrees with o_blink in the fetch cycle.
    // Fetch addresses never exceed COLS*ROWS-1, so out-of-grid cursors cannot match.
    assign hit_d = i_cur_en && blink_d && (cell_addr == i_cur_adr) && (gr_q >= GrCurMin);

    // Raster state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_q        <= '0;
            v_q        <= '0;
            px_q       <= '0;
            col_q      <= '0;
            gr_q       <= '0;
            row_base_q <= '0;
            fc_q       <= '0;
            blink_q    <= 1'b0;
        end else if (i_en) begin
            h_q        <= h_d;
            v_q        <= v_d;
            px_q       <= px_d;
            col_q      <= col_d;
            gr_q       <= gr_d;
            row_base_q <= row_base_d;
            fc_q       <= fc_d;
            blink_q    <= blink_d;
        end
    end

    // Fetch outputs: strobes every enabled cycle, address/row/hit held between fetches
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            re_q   <= 1'b0;
            fs_q   <= 1'b0;
            addr_q <= '0;
            row_q  <= '0;
            hit_q  <= 1'b0;
        end else if (i_en) begin
            re_q <= fetch;
            fs_q <= frame_evt;
            if (fetch) begin
                addr_q <= cell_addr;
                row_q  <= gr_q;
                hit_q  <= hit_d;
            end
        end
    end

    // Sync/DE delay line; reset flushes every stage so no partial pulse escapes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hs_pipe_q <= {(PIPE_DLY + 1){~HS_POL}};
            vs_pipe_q <= {(PIPE_DLY + 1){~VS_POL}};
            de_pipe_q <= '0;
        end else if (i_en) begin
            hs_pipe_q[0] <= hs_raw;
            vs_pipe_q[0] <= vs_raw;
            de_pipe_q[0] <= in_text;
            for (int i = 1; i <= int'(PIPE_DLY); i++) begin
                hs_pipe_q[i] <= hs_pipe_q[i-1];
                vs_pipe_q[i] <= vs_pipe_q[i-1];
                de_pipe_q[i] <= de_pipe_q[i-1];
            end
        end
    end

    // Strobes are only meaningful in enabled cycles; everything else holds
    always_comb begin
        o_vram_re     = re_q & i_en;
        o_frame_start = fs_q & i_en;
        o_vram_addr   = addr_q;
        o_glyph_row   = row_q;
        o_cursor_hit  = hit_q;
        o_blink       = blink_q;
        o_hs          = hs_pipe_q[PIPE_DLY];
        o_vs          = vs_pipe_q[PIPE_DLY];
        o_de          = de_pipe_q[PIPE_DLY];
    end

endmodule

// File: tb/tb_vga_text_timing.sv
// Bench for vga_text_timing in a small mode (48x32 raster, 6x5 grid of 4x4 cells) so several frames
// fit in a short run. A position-based model is compared every cycle; literal checks pin the model.
module tb_vga_text_timing;

    localparam int unsigned HA = 32, HFP = 4, HSW = 6, HBP = 6;
    localparam int unsigned VA = 24, VFP = 2, VSW = 2, VBP = 4;
    localparam int unsigned CW = 4, CH = 4, COLS = 6, ROWS = 5, AW = 6, PD = 2, BF = 2;
    localparam bit          HPOL = 1'b0, VPOL = 1'b1;
    localparam int HT    = HA + HFP + HSW + HBP;
    localparam int VT    = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int GW    = $clog2(CH);

    logic          clk = 1'b0;
    logic          rst = 1'b1, en = 1'b1, cur_en = 1'b0;
    logic [AW-1:0] cur = '0;
    logic          o_hs, o_vs, o_de, o_vram_re, o_cursor_hit, o_blink, o_frame_start;
    logic [AW-1:0] o_vram_addr;
    logic [GW-1:0] o_glyph_row;

    always #5 clk = ~clk;

    vga_text_timing #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HPOL), .VS_POL(VPOL), .CHAR_W(CW), .CHAR_H(CH), .COLS(COLS), .ROWS(ROWS),
        .ADDR_W(AW), .PIPE_DLY(PD), .BLINK_FRAMES(BF)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_cur_adr(cur), .i_cur_en(cur_en),
        .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_vram_re(o_vram_re),
        .o_vram_addr(o_vram_addr), .o_glyph_row(o_glyph_row), .o_cursor_hit(o_cursor_hit),
        .o_blink(o_blink), .o_frame_start(o_frame_start)
    );

    int n_checks = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                      name, got, got, exp, exp, $time);
    endtask

    function automatic logic [14:0] outs();
        return {o_hs, o_vs, o_de, o_vram_re, o_frame_start, o_blink, o_cursor_hit,
                o_glyph_row, o_vram_addr};
    endfunction

    // ---- model: everything derived from the raster position p (enabled cycles since reset) ----
    function automatic bit m_hs(input int d);
        int h;
        if (d < 0) return !HPOL;
        h = d % HT;
        return (h >= HA + HFP && h < HA + HFP + HSW) ? HPOL : !HPOL;
    endfunction

    function automatic bit m_vs(input int d);
        int v;
        if (d < 0) return !VPOL;
        v = (d / HT) % VT;
        return (v >= VA + VFP && v < VA + VFP + VSW) ? VPOL : !VPOL;
    endfunction

    function automatic bit m_de(input int d);
        if (d < 0) return 1'b0;
        return ((d % HT) < COLS * CW) && (((d / HT) % VT) < ROWS * CH);
    endfunction

    function automatic bit m_fetch(input int p);
        return m_de(p) && ((p % HT) % CW == 0);
    endfunction

    function automatic bit m_blink(input int p);
        if (p < 0) return 1'b0;
        return 1'(((p / FRAME + 1) / BF) % 2);
    endfunction

    int            k = -1, mh, mv;
    bit            model_ok = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [GW-1:0] m_row = '0;
    bit            m_hit = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            k = -1; m_addr = '0; m_row = '0; m_hit = 1'b0; model_ok = 1'b1;
        end else if (en && model_ok) begin
            k++;
            if (m_fetch(k)) begin
                mh = k % HT;
                mv = (k / HT) % VT;
                m_addr = AW'((mv / CH) * COLS + mh / CW);
                m_row  = GW'(mv % CH);
                m_hit  = cur_en && m_blink(k) && (int'(m_addr) == int'(cur)) && (mv % CH >= CH - 2);
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("per-cycle outputs {hs,vs,de,re,fs,blink,hit,row,addr}", 32'(outs()),
                  32'({m_hs(k - PD), m_vs(k - PD), m_de(k - PD), m_fetch(k) && en,
                       (k >= 0 && k % FRAME == 0) && en, m_blink(k), m_hit, m_row, m_addr}));
        end
    end

    // ---- measurements feeding the hand-computed checks ----
    int hs_fall0, hs_fall1, hs_rise0, vs_rise0, vs_fall0, hs_low_win;
    int nf, nf_line0, nf_frame0, last_addr, last_row, line4_re, line4_addr;
    int nhit, nblink_tog, nblink_hi, nfs, re_en0;
    int fa[3], fn[3];
    bit prev_hs, prev_vs, prev_blink;

    task automatic clear_meas();
        hs_fall0 = -1; hs_fall1 = -1; hs_rise0 = -1; vs_rise0 = -1; vs_fall0 = -1;
        hs_low_win = 0; nf = 0; nf_line0 = 0; nf_frame0 = 0; last_addr = -1; last_row = -1;
        line4_re = -1; line4_addr = -1; nhit = 0; nblink_tog = 0; nblink_hi = 0; nfs = 0;
        re_en0 = 0;
        for (int i = 0; i < 3; i++) begin fa[i] = -1; fn[i] = -1; end
        prev_hs = o_hs; prev_vs = o_vs; prev_blink = o_blink;
    endtask

    task automatic measure(input int n);
        if (prev_hs && !o_hs) begin
            if (hs_fall0 < 0) hs_fall0 = n;
            else if (hs_fall1 < 0) hs_fall1 = n;
        end
        if (!prev_hs && o_hs && hs_fall0 >= 0 && hs_rise0 < 0) hs_rise0 = n;
        if (!o_hs && n <= 2 * HT) hs_low_win++;
        if (!prev_vs && o_vs && vs_rise0 < 0) vs_rise0 = n;
        if (prev_vs && !o_vs && vs_rise0 >= 0 && vs_fall0 < 0) vs_fall0 = n;
        if (o_vram_re) begin
            if (nf < 3) begin fa[nf] = int'(o_vram_addr); fn[nf] = n; end
            nf++;
            if (n <= HT) nf_line0++;
            if (n <= FRAME) begin
                nf_frame0++; last_addr = int'(o_vram_addr); last_row = int'(o_glyph_row);
            end
            if (o_cursor_hit) nhit++;
            if (!en) re_en0++;
        end
        if (n == 4 * HT + 1) begin line4_re = int'(o_vram_re); line4_addr = int'(o_vram_addr); end
        if (o_blink != prev_blink) nblink_tog++;
        if (o_blink) nblink_hi++;
        if (o_frame_start) nfs++;
        prev_hs = o_hs; prev_vs = o_vs; prev_blink = o_blink;
    endtask

    // nxt_en applies to the coming edge and gates the strobes of the cycle after it
    task automatic cyc(input bit nxt_en);
        @(posedge clk);
        #1 en = nxt_en;
        @(negedge clk);
    endtask

    task automatic do_reset(input int edges);
        rst = 1'b1;
        en  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset outputs", 32'(outs()), 32'({1'b1, 1'b0, 13'b0}));
        repeat (edges - 1) @(posedge clk);
        #1 rst = 1'b0;
        en = 1'b1;
    endtask

    initial begin
        // A: defaults-style run, cursor on cell 7 (cell row 1, col 1), five frames
        do_reset(3);
        cur_en = 1'b1;
        cur    = 6'd7;
        clear_meas();
        for (int n = 1; n <= 5 * FRAME; n++) begin cyc(1'b1); measure(n); end
        check("hs first low", hs_fall0, 39);
        check("hs second low", hs_fall1, 87);
        check("hs inactive again", hs_rise0, 45);
        check("vs first active", vs_rise0, 1251);
        check("vs inactive again", vs_fall0, 1347);
        check("fetch0 addr", fa[0], 0);
        check("fetch0 time", fn[0], 1);
        check("fetch1 addr", fa[1], 1);
        check("fetch1 time", fn[1], 5);
        check("fetch2 addr", fa[2], 2);
        check("fetch2 time", fn[2], 9);
        check("fetches on line 0", nf_line0, 6);
        check("line 4 fetch strobe", line4_re, 1);
        check("line 4 first addr", line4_addr, 6);
        check("fetches in frame 0", nf_frame0, 120);
        check("last fetch addr", last_addr, 29);
        check("last fetch row", last_row, 3);
        check("frame starts", nfs, 5);
        check("blink toggles", nblink_tog, 2);
        check("cursor hits", nhit, 4);

        // B: cursor address just past the grid never hits, even while blinking
        cur = 6'd30;
        clear_meas();
        for (int n = 1; n <= 3 * FRAME; n++) begin cyc(1'b1); measure(n); end
        check("out-of-grid cursor hits", nhit, 0);
        check("blink-high cycles", nblink_hi, 2 * FRAME);
        check("frame starts B", nfs, 3);

        // C: reset while hs is active mid-line (v=10, h=38 in frame 9)
        for (int n = 1; n <= 2055; n++) cyc(1'b1);
        check("pre-reset hs", 32'(o_hs), 0);
        check("pre-reset blink", 32'(o_blink), 1);
        do_reset(1);
        clear_meas();
        for (int n = 1; n <= 100; n++) begin cyc(1'b1); measure(n); end
        check("hs first low after reset", hs_fall0, 39);
        check("fetch0 addr after reset", fa[0], 0);
        check("fetch0 time after reset", fn[0], 1);
        check("frame starts after reset", nfs, 1);

        // D: enable toggling 1/0 doubles every period
        do_reset(2);
        clear_meas();
        for (int n = 1; n <= 2 * FRAME; n++) begin cyc(n % 2 == 0); measure(n); end
        check("gated hs first low", hs_fall0, 77);
        check("gated hs low cycles", hs_low_win, 12);
        check("gated fetch0 time", fn[0], 2);
        check("gated fetches per frame", nf, 120);
        check("gated frame starts", nfs, 1);
        check("strobes with en low", re_en0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
